cache_refill_ctrl: RTL and testbench

//  Sequencing FSM for the set-associative data cache. Accepts one CPU request at a time and runs the tag lookup.
//  On a read miss, refills the victim way word-by-word from memory over valid/ready. Writes go through to memory.

---
 rtl/cache_refill_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_refill_ctrl                                          |
// | Description : Request sequencer for a set-associative data cache: tag    |
// |               lookup, word-by-word read-miss refill, write-through.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cache_refill_ctrl #(
    parameter  int ADDR_SIZE   = 32,
    parameter  int NUM_SETS    = 16,
    parameter  int NUM_WAYS    = 4,
    parameter  int BLOCK_WORDS = 4,
    localparam int SET_W       = $clog2(NUM_SETS),
    localparam int WAY_W       = $clog2(NUM_WAYS),
    localparam int WORD_W      = $clog2(BLOCK_WORDS),
    localparam int TAG_W       = ADDR_SIZE - 2 - WORD_W - SET_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    // CPU request / response
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic                 req_we,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    // tag / data array lookup
    output logic [SET_W-1:0]     lk_set,
    output logic [TAG_W-1:0]     lk_tag,
    output logic [WORD_W-1:0]    lk_word,
    input  logic                 hit,
    input  logic [WAY_W-1:0]     hit_way,
    input  logic [31:0]          hit_rdata,
    input  logic [WAY_W-1:0]     victim_way,
    // array writes and replacement notify
    output logic                 fill_en,
    output logic [WAY_W-1:0]     fill_way,
    output logic [31:0]          fill_data,
    output logic                 tag_we,
    output logic                 tag_valid,
    output logic                 cru_update,
    output logic [WAY_W-1:0]     cru_way,
    // memory side
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_SIZE-1:0] mem_req_addr,
    output logic                 mem_req_we,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_rdata
);

    localparam logic [WORD_W-1:0] c_last_word = WORD_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOOKUP      = 3'd1,
        S_REFILL_REQ  = 3'd2,
        S_REFILL_WAIT = 3'd3,
        S_WRITE_MEM   = 3'd4,
        S_RESPOND     = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [ADDR_SIZE-1:2]   r_addr;
    logic                   r_we;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic [WAY_W-1:0]       r_victim;
    logic [WORD_W-1:0]      r_cnt;

    logic                   w_accept;
    logic                   w_cap_hit;
    logic                   w_start_refill;
    logic                   w_beat;
    logic                   w_cap_beat;

    logic [WORD_W-1:0]      w_req_word;
    logic [SET_W-1:0]       w_set;
    logic [TAG_W-1:0]       w_tag;

    // Byte offset never reaches the arrays or memory; all traffic is word aligned.
    logic                   w_unused;
    assign w_unused = &{1'b0, req_addr[1:0]};

    assign w_req_word = r_addr[2 +: WORD_W];
    assign w_set      = r_addr[2 + WORD_W +: SET_W];
    assign w_tag      = r_addr[ADDR_SIZE-1 -: TAG_W];

    assign lk_set     = w_set;
    assign lk_tag     = w_tag;

    always_comb begin
        w_next_state   = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        lk_word        = w_req_word;
        fill_en        = 1'b0;
        fill_way       = '0;
        fill_data      = '0;
        tag_we         = 1'b0;
        tag_valid      = 1'b0;
        cru_update     = 1'b0;
        cru_way        = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        mem_req_we     = 1'b0;
        mem_wdata      = '0;
        w_accept       = 1'b0;
        w_cap_hit      = 1'b0;
        w_start_refill = 1'b0;
        w_beat         = 1'b0;
        w_cap_beat     = 1'b0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (!r_we && hit) begin
                    w_cap_hit    = 1'b1;
                    cru_update   = 1'b1;
                    cru_way      = hit_way;
                    w_next_state = S_RESPOND;
                end else if (!r_we) begin
                    // Invalidate the victim first so a partial refill never looks valid.
                    w_start_refill = 1'b1;
                    tag_we         = 1'b1;
                    tag_valid      = 1'b0;
                    fill_way       = victim_way;
                    w_next_state   = S_REFILL_REQ;
                end else begin
                    if (hit) begin
                        fill_en    = 1'b1;
                        fill_way   = hit_way;
                        fill_data  = r_wdata;
                        cru_update = 1'b1;
                        cru_way    = hit_way;
                    end
                    w_next_state = S_WRITE_MEM;
                end
            end

            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_tag, w_set, r_cnt, 2'b00};
                if (mem_req_ready) begin
                    w_next_state = S_REFILL_WAIT;
                end
            end

            S_REFILL_WAIT: begin
                lk_word = r_cnt;
                if (mem_resp_valid) begin
                    w_beat     = 1'b1;
                    w_cap_beat = (r_cnt == w_req_word);
                    fill_en    = 1'b1;
                    fill_way   = r_victim;
                    fill_data  = mem_rdata;
                    if (r_cnt == c_last_word) begin
                        tag_we       = 1'b1;
                        tag_valid    = 1'b1;
                        cru_update   = 1'b1;
                        cru_way      = r_victim;
                        w_next_state = S_RESPOND;
                    end else begin
                        w_next_state = S_REFILL_REQ;
                    end
                end
            end

            S_WRITE_MEM: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {r_addr, 2'b00};
                mem_wdata     = r_wdata;
                if (mem_req_ready) begin
                    w_next_state = S_RESPOND;
                end
            end

            S_RESPOND: begin
                resp_valid   = 1'b1;
                resp_rdata   = r_we ? 32'd0 : r_rdata;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_victim <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_addr  <= req_addr[ADDR_SIZE-1:2];
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_rdata <= '0;
            end

            if (w_cap_hit) begin
                r_rdata <= hit_rdata;
            end else if (w_cap_beat) begin
                r_rdata <= mem_rdata;
            end

            // The counter only restarts at refill start; it never wraps past the last word.
            if (w_start_refill) begin
                r_victim <= victim_way;
                r_cnt    <= '0;
            end else if (w_beat && (r_cnt != c_last_word)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cache_refill_ctrl                                       |
// | Description : Self-checking bench: directed vector table, corner-case    |
// |               sequences and randomized traffic against a request model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cache_refill_ctrl;

    localparam int ADDR_SIZE   = 32;
    localparam int NUM_SETS    = 16;
    localparam int NUM_WAYS    = 4;
    localparam int BLOCK_WORDS = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [3:0]  lk_set;
    logic [23:0] lk_tag;
    logic [1:0]  lk_word;
    logic        hit;
    logic [1:0]  hit_way, victim_way;
    logic [31:0] hit_rdata;
    logic        fill_en, tag_we, tag_valid, cru_update;
    logic [1:0]  fill_way, cru_way;
    logic [31:0] fill_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_refill_ctrl #(
        .ADDR_SIZE(ADDR_SIZE), .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS), .BLOCK_WORDS(BLOCK_WORDS)
    ) u_dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .lk_set(lk_set), .lk_tag(lk_tag), .lk_word(lk_word),
        .hit(hit), .hit_way(hit_way), .hit_rdata(hit_rdata), .victim_way(victim_way),
        .fill_en(fill_en), .fill_way(fill_way), .fill_data(fill_data),
        .tag_we(tag_we), .tag_valid(tag_valid),
        .cru_update(cru_update), .cru_way(cru_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct packed { logic [1:0] way; logic [1:0] word; logic [31:0] data; } fill_t;
    typedef struct packed { logic [1:0] way; logic valid; logic [3:0] set; logic [23:0] tag; } tagw_t;
    typedef struct packed { logic [31:0] addr; logic we; logic [31:0] data; } memrq_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        h;
        logic [1:0]  hw;
        logic [31:0] hrd;
        logic [1:0]  vw;
        logic [31:0] exp_rdata;
        int          exp_nfill;
        int          exp_nmem;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    fill_t      act_fill[$], exp_fill[$];
    tagw_t      act_tag[$],  exp_tag[$];
    memrq_t     act_mem[$],  exp_mem[$];
    logic [1:0] act_cru[$],  exp_cru[$];
    int          resp_cnt, resp_cycle, acc_cycle, stall_cycles;
    logic [31:0] resp_data;
    bit          acc_seen;

    // memory model: one outstanding read, answered resp_delay cycles after acceptance
    bit          mem_mode;
    int          resp_delay, stall_left, pend_cnt;
    bit          pend_valid, stall_chk;
    logic [31:0] pend_addr, stall_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (!mem_mode) return 32'hA0 + {28'd0, a[3:2]};
        return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_stall(input int n);
        stall_left    = n;
        mem_req_ready = (n == 0);
    endtask

    task automatic clear_obs();
        act_fill.delete(); act_tag.delete(); act_mem.delete(); act_cru.delete();
        resp_cnt = 0; acc_seen = 0; stall_cycles = 0;
    endtask

    // Observe the settled pre-edge outputs, then advance one clock and drive memory.
    task automatic step();
        #1;
        if (req_valid && req_ready) begin acc_seen = 1; acc_cycle = cycle; end
        if (fill_en)    act_fill.push_back(fill_t'{fill_way, lk_word, fill_data});
        if (tag_we)     act_tag.push_back(tagw_t'{fill_way, tag_valid, lk_set, lk_tag});
        if (cru_update) act_cru.push_back(cru_way);
        if (resp_valid) begin resp_cnt++; resp_data = resp_rdata; resp_cycle = cycle; end
        if (stall_chk) begin
            check("stall_valid_held", 64'(mem_req_valid), 64'd1);
            check("stall_addr_stable", 64'(mem_req_addr), 64'(stall_addr));
        end
        stall_chk = mem_req_valid && !mem_req_ready;
        if (stall_chk) begin
            check("stall_no_fill", 64'(fill_en), 64'd0);
            stall_addr = mem_req_addr;
            stall_cycles++;
            if (stall_left > 0) stall_left--;
        end
        if (mem_resp_valid) pend_valid = 0;
        if (mem_req_valid && mem_req_ready) begin
            act_mem.push_back(memrq_t'{mem_req_addr, mem_req_we, mem_wdata});
            if (!mem_req_we) begin pend_valid = 1; pend_addr = mem_req_addr; pend_cnt = resp_delay; end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
        mem_req_ready = (stall_left == 0);
        if (pend_valid && pend_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_data(pend_addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
            if (pend_valid) pend_cnt--;
        end
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0; pend_valid = 0; stall_chk = 0; mem_resp_valid = 1'b0; set_stall(0);
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_req_ready", 64'(req_ready), 64'd1);
            check("rst_strobes", 64'({resp_valid, fill_en, tag_we, mem_req_valid, cru_update}), 64'd0);
            step();
        end
        rstn = 1'b1;
    endtask

    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic h, input logic [1:0] hw,
                           input logic [31:0] hrd, input logic [1:0] vw);
        logic [31:0] exp_rdata;
        logic [31:0] base;
        clear_obs();
        exp_fill.delete(); exp_tag.delete(); exp_mem.delete(); exp_cru.delete();
        base      = {addr[31:4], 4'h0};
        exp_rdata = 32'd0;
        if (!we && h) begin
            exp_cru.push_back(hw);
            exp_rdata = hrd;
        end else if (!we) begin
            exp_tag.push_back(tagw_t'{vw, 1'b0, addr[7:4], addr[31:8]});
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                exp_mem.push_back(memrq_t'{base + 32'(4 * w), 1'b0, 32'd0});
                exp_fill.push_back(fill_t'{vw, 2'(w), mem_data(base + 32'(4 * w))});
            end
            exp_tag.push_back(tagw_t'{vw, 1'b1, addr[7:4], addr[31:8]});
            exp_cru.push_back(vw);
            exp_rdata = mem_data({addr[31:2], 2'b00});
        end else begin
            if (h) begin
                exp_fill.push_back(fill_t'{hw, addr[3:2], wdata});
                exp_cru.push_back(hw);
            end
            exp_mem.push_back(memrq_t'{{addr[31:2], 2'b00}, 1'b1, wdata});
        end

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        hit = h; hit_way = hw; hit_rdata = hrd; victim_way = vw;
        for (int i = 0; i < 400 && resp_cnt == 0; i++) begin
            step();
            if (acc_seen) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        step();

        check({name, "_accepted"}, 64'(acc_seen), 64'd1);
        check({name, "_resp_once"}, 64'(resp_cnt), 64'd1);
        check({name, "_rdata"}, 64'(resp_data), 64'(exp_rdata));
        if (!we && h) check({name, "_hit_latency"}, 64'(resp_cycle - acc_cycle), 64'd2);
        check({name, "_nfill"}, 64'(act_fill.size()), 64'(exp_fill.size()));
        for (int i = 0; i < act_fill.size() && i < exp_fill.size(); i++)
            check({name, "_fill"}, 64'(act_fill[i]), 64'(exp_fill[i]));
        check({name, "_ntag"}, 64'(act_tag.size()), 64'(exp_tag.size()));
        for (int i = 0; i < act_tag.size() && i < exp_tag.size(); i++)
            check({name, "_tag"}, 64'(act_tag[i]), 64'(exp_tag[i]));
        check({name, "_ncru"}, 64'(act_cru.size()), 64'(exp_cru.size()));
        for (int i = 0; i < act_cru.size() && i < exp_cru.size(); i++)
            check({name, "_cru_way"}, 64'(act_cru[i]), 64'(exp_cru[i]));
        check({name, "_nmem"}, 64'(act_mem.size()), 64'(exp_mem.size()));
        for (int i = 0; i < act_mem.size() && i < exp_mem.size(); i++) begin
            check({name, "_mem_addr"}, 64'(act_mem[i].addr), 64'(exp_mem[i].addr));
            check({name, "_mem_we"}, 64'(act_mem[i].we), 64'(exp_mem[i].we));
            if (exp_mem[i].we) check({name, "_mem_wdata"}, 64'(act_mem[i].data), 64'(exp_mem[i].data));
        end
    endtask

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nv;
        vecs[0] = '{1'b0, 32'h0000_1234, 32'h0, 1'b1, 2'd2, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 0, 0};
        vecs[1] = '{1'b0, 32'h0000_1234, 32'h0, 1'b0, 2'd0, 32'h0,         2'd1, 32'h0000_00A1, 4, 4};
        vecs[2] = '{1'b1, 32'h0000_0040, 32'h55, 1'b1, 2'd3, 32'h0,        2'd0, 32'h0,         1, 1};
        vecs[3] = '{1'b1, 32'h0000_0040, 32'h55, 1'b0, 2'd3, 32'h0,        2'd0, 32'h0,         0, 1};
        vecs[4] = '{1'b0, 32'h0000_123C, 32'h0, 1'b0, 2'd0, 32'h0,         2'd3, 32'h0000_00A3, 4, 4};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0, 1'b1, 2'd0, 32'h0000_0001, 2'd2, 32'h0000_0001, 0, 0};

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        hit = 1'b0; hit_way = '0; hit_rdata = '0; victim_way = '0;
        mem_resp_valid = 1'b0; mem_rdata = '0; mem_req_ready = 1'b1;
        mem_mode = 0; resp_delay = 0; pend_valid = 0; pend_cnt = 0; stall_chk = 0;
        stall_left = 0; stall_addr = '0; pend_addr = '0; resp_data = '0;
        resp_cycle = 0; acc_cycle = 0;
        clear_obs();
        @(negedge clk);
        do_reset(3);

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].h, vecs[i].hw, vecs[i].hrd, vecs[i].vw);
            check($sformatf("vec%0d_tbl_rdata", i), 64'(resp_data), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_tbl_nfill", i), 64'(act_fill.size()), 64'(vecs[i].exp_nfill));
            check($sformatf("vec%0d_tbl_nmem", i), 64'(act_mem.size()), 64'(vecs[i].exp_nmem));
        end

        // memory request back-pressure during a refill
        set_stall(5);
        run_txn("stall", 1'b0, 32'h0000_1234, 32'h0, 1'b0, 2'd0, 32'h0, 2'd1);
        check("stall_cycles", 64'(stall_cycles), 64'd5);

        // reset while idle
        do_reset(3);

        // reset after two refill beats
        mem_mode = 1; resp_delay = 1; set_stall(0);
        clear_obs();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5678; hit = 1'b0; victim_way = 2'd2;
        for (int i = 0; i < 100 && act_fill.size() < 2; i++) begin
            step();
            if (acc_seen) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("midrst_two_beats", 64'(act_fill.size()), 64'd2);
        do_reset(1);
        nv = 0;
        foreach (act_tag[i]) if (act_tag[i].valid) nv++;
        check("midrst_no_valid_tag", 64'(nv), 64'd0);
        check("midrst_ntag", 64'(act_tag.size()), 64'd1);
        #1;
        check("midrst_idle_ready", 64'(req_ready), 64'd1);
        run_txn("post_rst_miss", 1'b0, 32'h0000_5678, 32'h0, 1'b0, 2'd0, 32'h0, 2'd2);
        run_txn("post_rst_hit", 1'b0, 32'hCAFE_0010, 32'h0, 1'b1, 2'd1, 32'h1357_9BDF, 2'd0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            resp_delay = int'($urandom_range(0, 2));
            set_stall(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                    2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
